bw_frame_buffer: RTL

//  Single-clock 1-bit frame store between sobel2black_white and the VGA path.

---
 rtl/bw_frame_buffer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/bw_frame_buffer.sv
// -----------------------------------------------------------------------------
// bw_frame_buffer
//
// Single-clock 1-bit frame store. It sits between the sobel2black_white stage
// and the VGA output path. The incoming raster-ordered black/white stream is
// captured into an IMG_W x IMG_H bit memory. The stored image is replayed inside
// a fixed window of the VGA raster, addressed by the VGA controller's x/y.
// Because of this, the picture on screen does not depend on when pixels arrive
// over UART. Outside the window, or before the first complete frame has been
// stored, the output is black (0).
//
// Ports
//   clk          in   1      system clock (same clock as the sobel chain)
//   reset        in   1      asynchronous, active-high reset
//   wr_bit       in   1      incoming pixel (1 = edge / white)
//   wr_valid     in   1      wr_bit is valid this cycle
//   frame_start  in   1      1-cycle pulse: the next accepted pixel is (0,0)
//   pix_en       in   1      VGA pixel tick; at least 2 clk between ticks
//   vga_x        in   XY_W   current VGA column
//   vga_y        in   XY_W   current VGA row
//   video_on     in   1      VGA active-area flag
//   pix_out      out  1      pixel to the VGA colour input
//   frame_valid  out  1      at least one full frame stored since reset (sticky)
//   frame_done   out  1      1-cycle pulse after the last pixel of a frame is written
//   wr_line      out  clog2(IMG_H)  line currently being written
//
// Transfer semantics: the write side has no back-pressure. Every cycle in which
// wr_valid is high transfers exactly one pixel (wr_bit), and that pixel is always
// accepted. The read side is a fixed-latency pipeline. A clk edge with pix_en=1
// samples the VGA coordinates. On the following edge pix_out is updated. It then
// holds its value until the next tick.
// -----------------------------------------------------------------------------
module bw_frame_buffer #(
    parameter int IMG_W = 256,  // stored image width (power of 2)
    parameter int IMG_H = 256,  // stored image height
    parameter int H_OFF = 192,  // VGA column of the window's left edge
    parameter int V_OFF = 112,  // VGA row of the window's top edge
    parameter int XY_W  = 10    // width of the VGA x/y inputs
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_bit,
    input  logic                       wr_valid,
    input  logic                       frame_start,
    input  logic                       pix_en,
    input  logic [XY_W-1:0]            vga_x,
    input  logic [XY_W-1:0]            vga_y,
    input  logic                       video_on,
    output logic                       pix_out,
    output logic                       frame_valid,
    output logic                       frame_done,
    output logic [$clog2(IMG_H)-1:0]   wr_line
);

    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);
    localparam int AW    = XW + YW;
    localparam int DEPTH = IMG_W * IMG_H;

    localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

    // Window bounds are held one bit wider than the coordinates. This keeps
    // H_OFF+IMG_W from overflowing the XY_W-bit range.
    localparam logic [XY_W:0] X_LO = (XY_W+1)'(H_OFF);
    localparam logic [XY_W:0] X_HI = (XY_W+1)'(H_OFF + IMG_W);
    localparam logic [XY_W:0] Y_LO = (XY_W+1)'(V_OFF);
    localparam logic [XY_W:0] Y_HI = (XY_W+1)'(V_OFF + IMG_H);

    // -------------------------------------------------------------------------
    // Write-side FSM
    //   EMPTY : nothing received since reset
    //   FILL  : a frame is being written
    //   READY : the last pixel of a frame was written; waiting for the next one
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILL  = 2'd1,
        ST_READY = 2'd2
    } wr_state_t;

    wr_state_t       state;
    wr_state_t       state_nxt;

    logic [XW-1:0]   wr_x;
    logic [YW-1:0]   wr_y;
    logic [XW-1:0]   base_x;
    logic [YW-1:0]   base_y;
    logic [XW-1:0]   wr_x_nxt;
    logic [YW-1:0]   wr_y_nxt;
    logic            last_px;
    logic [AW-1:0]   waddr;

    // frame_start rewinds the pointer before this cycle's pixel is placed. So a
    // pixel that arrives together with frame_start lands at (0,0).
    always_comb begin
        base_x   = frame_start ? '0 : wr_x;
        base_y   = frame_start ? '0 : wr_y;
        waddr    = {base_y, base_x};
        last_px  = wr_valid && (base_x == X_MAX) && (base_y == Y_MAX);
        wr_x_nxt = base_x;
        wr_y_nxt = base_y;
        if (wr_valid) begin
            wr_x_nxt = (base_x == X_MAX) ? '0 : base_x + XW'(1);
            if (base_x == X_MAX) begin
                wr_y_nxt = (base_y == Y_MAX) ? '0 : base_y + YW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY,
            ST_READY: begin
                if (last_px) begin
                    state_nxt = ST_READY;
                end else if (wr_valid || frame_start) begin
                    state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                if (last_px) begin
                    state_nxt = ST_READY;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_EMPTY;
            wr_x        <= '0;
            wr_y        <= '0;
            frame_valid <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_x       <= wr_x_nxt;
            wr_y       <= wr_y_nxt;
            frame_done <= last_px;
            if (last_px) begin
                frame_valid <= 1'b1;
            end
        end
    end

    assign wr_line = wr_y;

    // -------------------------------------------------------------------------
    // Read-side address stage
    // The window test uses the raw coordinates. The address is only meaningful
    // when in_win is set, so the wrapped result of the subtraction outside the
    // window is never used. Only the low bits of the XY_W-wide difference are
    // needed, and they are identical when the subtraction is done at index
    // width.
    // -------------------------------------------------------------------------
    logic            in_win;
    logic [XW-1:0]   rd_col;
    logic [YW-1:0]   rd_row;
    logic [AW-1:0]   raddr;

    always_comb begin
        in_win = video_on
                 && ({1'b0, vga_x} >= X_LO) && ({1'b0, vga_x} < X_HI)
                 && ({1'b0, vga_y} >= Y_LO) && ({1'b0, vga_y} < Y_HI);
        rd_col = vga_x[XW-1:0] - XW'(H_OFF);
        rd_row = vga_y[YW-1:0] - YW'(V_OFF);
        raddr  = {rd_row, rd_col};
    end

    logic            rd_pend;   // previous edge was a pixel tick
    logic [AW-1:0]   raddr_r;
    logic            in_win_r;
    logic            pix_gate;  // window and frame_valid qualifier for rd_bit

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend  <= 1'b0;
            raddr_r  <= '0;
            in_win_r <= 1'b0;
            pix_gate <= 1'b0;
        end else begin
            rd_pend <= pix_en;
            if (pix_en) begin
                raddr_r  <= raddr;
                in_win_r <= in_win;
            end
            if (rd_pend) begin
                pix_gate <= in_win_r & frame_valid;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Bit memory: one write port and one registered read port, with no reset,
    // so that it maps onto block RAM. Both ports are written as non-blocking
    // assignments on the same edge. As a result, a read of the address being
    // written returns the old bit.
    // -------------------------------------------------------------------------
    logic mem [0:DEPTH-1];
    logic rd_bit;

    always_ff @(posedge clk) begin
        if (wr_valid) begin
            mem[waddr] <= wr_bit;
        end
        if (rd_pend) begin
            rd_bit <= mem[raddr_r];
        end
    end

    // pix_gate is cleared by reset, so the output goes black as soon as reset
    // is asserted, even though rd_bit itself is not reset.
    assign pix_out = pix_gate & rd_bit;

endmodule
